// File: rtl/l2_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// l2_req_arbiter_if
// Bundles every handshake and data signal between the L1 requesters, the
// request arbiter and the L2 cache.
//
// Signals:
//   req_valid/req_rw/req_addr/req_data/req_id  L1 requests, packed per requester
//   req_stall                                  holding register full, per requester
//   l2_valid/l2_rw/l2_addr/l2_data/l2_id       registered request to L2
//   l2_stall                                   L2 cannot accept this cycle
//   rsp_valid/rsp_data/rsp_id                  read response from L2
//   out_valid/out_data/out_id                  response routed back, per requester
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (L1 caches plus L2)
// -----------------------------------------------------------------------------
interface l2_req_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int NUM_REQ_LOG = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 256,
  parameter int ID_BITS     = 3
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_rw;
  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_addr;
  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data;
  logic [ID_BITS*NUM_REQ-1:0]     req_id;
  logic [NUM_REQ-1:0]             req_stall;

  logic                           l2_valid;
  logic                           l2_rw;
  logic [ADDR_WIDTH-1:0]          l2_addr;
  logic [DATA_WIDTH-1:0]          l2_data;
  logic [ID_BITS+NUM_REQ_LOG-1:0] l2_id;
  logic                           l2_stall;

  logic                           rsp_valid;
  logic [DATA_WIDTH-1:0]          rsp_data;
  logic [ID_BITS+NUM_REQ_LOG-1:0] rsp_id;

  logic [NUM_REQ-1:0]             out_valid;
  logic [DATA_WIDTH*NUM_REQ-1:0]  out_data;
  logic [ID_BITS*NUM_REQ-1:0]     out_id;

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_id,
    output req_stall,
    output l2_valid, l2_rw, l2_addr, l2_data, l2_id,
    input  l2_stall,
    input  rsp_valid, rsp_data, rsp_id,
    output out_valid, out_data, out_id
  );

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_id,
    input  req_stall,
    input  l2_valid, l2_rw, l2_addr, l2_data, l2_id,
    output l2_stall,
    output rsp_valid, rsp_data, rsp_id,
    input  out_valid, out_data, out_id
  );
endinterface

// File: rtl/l2_req_arbiter.sv
// -----------------------------------------------------------------------------
// l2_req_arbiter
// Shares one L2 request port among NUM_REQ L1 caches. Each requester owns a
// one-entry holding register; a round-robin arbiter moves eligible held
// requests into a single registered output stage, tagging each with the
// requester index. Outstanding reads are counted per requester (capped at
// MAX_OUT) and L2 read responses are routed back by tag, one cycle later.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - l2_req_arbiter_if.slave (requests, L2 port, responses)
// The interface instance must use the same parameter values as this module.
// -----------------------------------------------------------------------------
module l2_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int NUM_REQ_LOG = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 256,
  parameter int ID_BITS     = 3,
  parameter int MAX_OUT     = 4
) (
  input  logic             clk,
  input  logic             reset,
  l2_req_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int TAG_W = ID_BITS + NUM_REQ_LOG;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  // Holding registers, one entry per requester
  logic [NUM_REQ-1:0]    hold_valid_r;
  logic [NUM_REQ-1:0]    hold_rw_r;
  logic [ADDR_WIDTH-1:0] hold_addr_r [NUM_REQ];
  logic [DATA_WIDTH-1:0] hold_data_r [NUM_REQ];
  logic [ID_BITS-1:0]    hold_id_r   [NUM_REQ];

  // Outstanding read counters and round-robin pointer
  logic [CNT_W-1:0]       cnt_r [NUM_REQ];
  logic [NUM_REQ_LOG-1:0] last_grant_r;

  // Output stage and response registers
  logic                          l2_valid_r;
  logic                          l2_rw_r;
  logic [ADDR_WIDTH-1:0]         l2_addr_r;
  logic [DATA_WIDTH-1:0]         l2_data_r;
  logic [TAG_W-1:0]              l2_id_r;
  logic [NUM_REQ-1:0]            out_valid_r;
  logic [DATA_WIDTH*NUM_REQ-1:0] out_data_r;
  logic [ID_BITS*NUM_REQ-1:0]    out_id_r;

  // Combinational decisions
  logic [NUM_REQ-1:0]     eligible_s;
  logic [NUM_REQ-1:0]     accept_s;
  logic [NUM_REQ-1:0]     release_s;
  logic [NUM_REQ-1:0]     inc_s;
  logic [NUM_REQ-1:0]     dec_s;
  logic                   can_load_s;
  logic                   grant_valid_s;
  logic                   grant_fire_s;
  logic [NUM_REQ_LOG-1:0] grant_idx_s;
  logic [NUM_REQ_LOG-1:0] scan_idx_s;
  logic                   take_s;
  logic [NUM_REQ_LOG-1:0] rsp_req_s;

  assign can_load_s   = ~l2_valid_r | ~bus.l2_stall;
  assign grant_fire_s = can_load_s & grant_valid_s;
  assign rsp_req_s    = bus.rsp_id[TAG_W-1 -: NUM_REQ_LOG];

  // Per-requester accept, eligibility, release and counter events
  always_comb begin
    eligible_s = '0;
    accept_s   = '0;
    release_s  = '0;
    inc_s      = '0;
    dec_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // A read stays parked while its requester is at the outstanding cap;
      // it is simply skipped so other requesters keep flowing.
      eligible_s[i] = hold_valid_r[i] & (hold_rw_r[i] | (cnt_r[i] < CNT_MAX));
      accept_s[i]   = bus.req_valid[i] & ~hold_valid_r[i];
      release_s[i]  = grant_fire_s & (grant_idx_s == NUM_REQ_LOG'(i));
      inc_s[i]      = release_s[i] & ~hold_rw_r[i];
      // Tags outside the requester range match no index and are dropped
      dec_s[i]      = bus.rsp_valid & (rsp_req_s == NUM_REQ_LOG'(i));
    end
  end

  // Round-robin scan starting just after the last granted requester
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    scan_idx_s    = '0;
    take_s        = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx_s    = NUM_REQ_LOG'((int'(last_grant_r) + k) % NUM_REQ);
      take_s        = ~grant_valid_s & eligible_s[scan_idx_s];
      grant_idx_s   = take_s ? scan_idx_s : grant_idx_s;
      grant_valid_s = grant_valid_s | take_s;
    end
  end

  // Holding registers: capture on accept, free on grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_r <= '0;
      hold_rw_r    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_addr_r[i] <= '0;
        hold_data_r[i] <= '0;
        hold_id_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        // A slot freed by a grant is still stalled this cycle, so accept and
        // release can never hit the same slot on the same edge.
        if (accept_s[i]) begin
          hold_valid_r[i] <= 1'b1;
          hold_rw_r[i]    <= bus.req_rw[i];
          hold_addr_r[i]  <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          hold_data_r[i]  <= bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
          hold_id_r[i]    <= bus.req_id[i*ID_BITS +: ID_BITS];
        end else if (release_s[i]) begin
          hold_valid_r[i] <= 1'b0;
        end else begin
          hold_valid_r[i] <= hold_valid_r[i];
        end
      end
    end
  end

  // Outstanding read counters, saturating at both ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10: cnt_r[i] <= (cnt_r[i] == CNT_MAX) ? cnt_r[i] : cnt_r[i] + CNT_W'(1);
          2'b01: cnt_r[i] <= (cnt_r[i] == '0)      ? cnt_r[i] : cnt_r[i] - CNT_W'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Output stage: load the winner, drain when idle, freeze under L2 stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l2_valid_r   <= 1'b0;
      l2_rw_r      <= 1'b0;
      l2_addr_r    <= '0;
      l2_data_r    <= '0;
      l2_id_r      <= '0;
      last_grant_r <= NUM_REQ_LOG'(NUM_REQ - 1);
    end else if (can_load_s) begin
      if (grant_valid_s) begin
        l2_valid_r   <= 1'b1;
        l2_rw_r      <= hold_rw_r[grant_idx_s];
        l2_addr_r    <= hold_addr_r[grant_idx_s];
        l2_data_r    <= hold_data_r[grant_idx_s];
        l2_id_r      <= {grant_idx_s, hold_id_r[grant_idx_s]};
        last_grant_r <= grant_idx_s;
      end else begin
        l2_valid_r   <= 1'b0;
      end
    end else begin
      l2_valid_r <= l2_valid_r;
    end
  end

  // Response routing: one-cycle pulse to the tagged requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= '0;
      out_data_r  <= '0;
      out_id_r    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        out_valid_r[i] <= dec_s[i];
        if (dec_s[i]) begin
          out_data_r[i*DATA_WIDTH +: DATA_WIDTH] <= bus.rsp_data;
          out_id_r[i*ID_BITS +: ID_BITS]         <= bus.rsp_id[ID_BITS-1:0];
        end else begin
          out_id_r[i*ID_BITS +: ID_BITS] <= out_id_r[i*ID_BITS +: ID_BITS];
        end
      end
    end
  end

  assign bus.req_stall = hold_valid_r;
  assign bus.l2_valid  = l2_valid_r;
  assign bus.l2_rw     = l2_rw_r;
  assign bus.l2_addr   = l2_addr_r;
  assign bus.l2_data   = l2_data_r;
  assign bus.l2_id     = l2_id_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_id    = out_id_r;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_req_arbiter
// Randomized bench for l2_req_arbiter. Requesters hold a pending request until
// it is accepted; an L2 model stalls at random and returns responses for reads
// it has taken. A transaction-level reference model predicts every output.
// -----------------------------------------------------------------------------
module tb_l2_req_arbiter;

  localparam int NR  = 2;
  localparam int NRL = 1;
  localparam int AW  = 32;
  localparam int DW  = 256;
  localparam int IB  = 3;
  localparam int MO  = 4;

  typedef struct {
    bit          v;
    bit          rw;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [2:0]   id;
  } slot_t;

  logic clk;
  logic reset;

  l2_req_arbiter_if #(.NUM_REQ(NR), .NUM_REQ_LOG(NRL), .ADDR_WIDTH(AW),
                      .DATA_WIDTH(DW), .ID_BITS(IB)) bus ();

  l2_req_arbiter #(.NUM_REQ(NR), .NUM_REQ_LOG(NRL), .ADDR_WIDTH(AW),
                   .DATA_WIDTH(DW), .ID_BITS(IB), .MAX_OUT(MO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment state
  slot_t       pend [NR];
  logic [3:0]  inflight [$];
  bit          stall_d;
  bit          rsp_v_d;
  logic [3:0]  rsp_tag_d;
  logic [255:0] rsp_data_d;
  int req_pct, wr_pct, stall_pct, rsp_pct;

  // Reference model state
  slot_t        m_hold [NR];
  int           m_cnt  [NR];
  int           m_last;
  bit           m_l2_v;
  bit           m_l2_rw;
  logic [31:0]  m_l2_addr;
  logic [255:0] m_l2_data;
  logic [3:0]   m_l2_id;
  logic [1:0]   m_out_v;
  logic [255:0] m_out_data [NR];
  logic [2:0]   m_out_id   [NR];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_hold[i].v   = 1'b0;
      m_cnt[i]      = 0;
      m_out_data[i] = '0;
      m_out_id[i]   = '0;
    end
    m_last    = NR - 1;
    m_l2_v    = 1'b0;
    m_l2_rw   = 1'b0;
    m_l2_addr = '0;
    m_l2_data = '0;
    m_l2_id   = '0;
    m_out_v   = '0;
    inflight.delete();
  endtask

  // Choose and apply this cycle's inputs
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (!pend[i].v && $urandom_range(0, 99) < req_pct) begin
        pend[i].v    = 1'b1;
        pend[i].rw   = ($urandom_range(0, 99) < wr_pct);
        pend[i].addr = $urandom;
        pend[i].data = rand256();
        pend[i].id   = 3'($urandom_range(0, 7));
      end
      bus.req_valid[i]           = pend[i].v;
      bus.req_rw[i]              = pend[i].rw;
      bus.req_addr[i*AW +: AW]   = pend[i].addr;
      bus.req_data[i*DW +: DW]   = pend[i].data;
      bus.req_id[i*IB +: IB]     = pend[i].id;
    end
    stall_d      = ($urandom_range(0, 99) < stall_pct);
    bus.l2_stall = stall_d;
    rsp_v_d      = 1'b0;
    rsp_tag_d    = 4'($urandom_range(0, 15));
    rsp_data_d   = rand256();
    if (inflight.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
      int k;
      k = $urandom_range(0, inflight.size() - 1);
      rsp_v_d   = 1'b1;
      rsp_tag_d = inflight[k];
      inflight.delete(k);
    end
    bus.rsp_valid = rsp_v_d;
    bus.rsp_id    = rsp_tag_d;
    bus.rsp_data  = rsp_data_d;
  endtask

  // Advance the reference model across one clock edge
  task automatic model_step();
    int  g;
    bit  can;
    int  r;
    g   = -1;
    can = !m_l2_v || !stall_d;
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (m_last + k) % NR;
      if (g < 0 && m_hold[idx].v && (m_hold[idx].rw || m_cnt[idx] < MO)) g = idx;
    end
    // L2 takes the presented request; reads become eligible for a response
    if (m_l2_v && !stall_d && !m_l2_rw) inflight.push_back(m_l2_id);
    if (can && g >= 0 && !m_hold[g].rw) m_cnt[g] = m_cnt[g] + 1;
    m_out_v = '0;
    if (rsp_v_d) begin
      r = int'(rsp_tag_d[3]);
      m_cnt[r]      = m_cnt[r] - 1;
      m_out_v[r]    = 1'b1;
      m_out_data[r] = rsp_data_d;
      m_out_id[r]   = rsp_tag_d[2:0];
    end
    if (can) begin
      if (g >= 0) begin
        m_l2_v    = 1'b1;
        m_l2_rw   = m_hold[g].rw;
        m_l2_addr = m_hold[g].addr;
        m_l2_data = m_hold[g].data;
        m_l2_id   = {1'(g), m_hold[g].id};
        m_last    = g;
      end else begin
        m_l2_v = 1'b0;
      end
    end
    for (int i = 0; i < NR; i++) begin
      bit was;
      was = m_hold[i].v;
      if (can && g == i) m_hold[i].v = 1'b0;
      if (pend[i].v && !was) begin
        m_hold[i]  = pend[i];
        pend[i].v  = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("req_stall", bus.req_stall, {m_hold[1].v, m_hold[0].v});
    chk("l2_valid", bus.l2_valid, m_l2_v);
    if (m_l2_v) begin
      chk("l2_rw",   bus.l2_rw,   m_l2_rw);
      chk("l2_addr", bus.l2_addr, m_l2_addr);
      chk("l2_data", bus.l2_data, m_l2_data);
      chk("l2_id",   bus.l2_id,   m_l2_id);
    end
    chk("out_valid", bus.out_valid, m_out_v);
    for (int i = 0; i < NR; i++) begin
      if (m_out_v[i]) begin
        chk("out_data", bus.out_data[i*DW +: DW], m_out_data[i]);
        chk("out_id",   bus.out_id[i*IB +: IB],   m_out_id[i]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_stall"}, bus.req_stall, 2'b00);
    chk({tag, "_l2_valid"},  bus.l2_valid,  1'b0);
    chk({tag, "_l2_rw"},     bus.l2_rw,     1'b0);
    chk({tag, "_l2_addr"},   bus.l2_addr,   32'h0);
    chk({tag, "_l2_data"},   bus.l2_data,   256'h0);
    chk({tag, "_l2_id"},     bus.l2_id,     4'h0);
    chk({tag, "_out_valid"}, bus.out_valid, 2'b00);
    chk({tag, "_out_data0"}, bus.out_data[255:0],   256'h0);
    chk({tag, "_out_data1"}, bus.out_data[511:256], 256'h0);
    chk({tag, "_out_id"},    bus.out_id,    6'h0);
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      drive();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
    end
  endtask

  task automatic set_mix(input int rq, input int wr, input int st, input int rs);
    req_pct = rq; wr_pct = wr; stall_pct = st; rsp_pct = rs;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) pend[i].v = 1'b0;
    bus.req_valid = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_id    = '0;
    bus.l2_stall  = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_id    = '0;
    stall_d = 1'b0; rsp_v_d = 1'b0; rsp_tag_d = '0; rsp_data_d = '0;
    model_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Mixed traffic with random L2 stalls
    set_mix(60, 30, 20, 50);
    run_cycles(400);
    // Saturating reads with slow responses: outstanding cap reached
    set_mix(100, 0, 0, 5);
    run_cycles(200);
    // Writes must keep flowing past blocked reads
    set_mix(100, 50, 0, 5);
    run_cycles(200);
    // Heavy stall so both holds and the output stage fill up
    set_mix(100, 20, 90, 20);
    run_cycles(30);

    // Asynchronous reset mid-transfer
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Simultaneous reads after reset: requester 0 must win first
    for (int i = 0; i < NR; i++) begin
      pend[i].v    = 1'b1;
      pend[i].rw   = 1'b0;
      pend[i].addr = 32'h40 + 32'(i);
      pend[i].data = rand256();
      pend[i].id   = 3'd5;
    end
    set_mix(100, 0, 0, 0);
    run_cycles(2);
    chk("first_winner_valid", bus.l2_valid, 1'b1);
    chk("first_winner_idx",   bus.l2_id[3], 1'b0);

    // Final mixed traffic
    set_mix(80, 30, 30, 40);
    run_cycles(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
- Shares one L2 request port among NUM_REQ L1 caches.
- Each requester has a one-entry holding register. A round-robin arbiter moves held requests into a single registered output stage.
- The arbiter tags each request with the requester index. It counts outstanding reads per requester and routes L2 responses back by tag.
- Sits between the L1_cache instances and L2_cache, in place of a FIFO-based crossbar.

Parameters:
- NUM_REQ, 2, number of L1 requesters.
- NUM_REQ_LOG, 1, log2(NUM_REQ), minimum 1.
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 256, line width (32*WORDS).
- ID_BITS, 3, MSHR id width per requester.
- MAX_OUT, 4, maximum outstanding reads per requester.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_rw  in  NUM_REQ  1=write, 0=read.
- req_addr  in  ADDR_WIDTH*NUM_REQ  packed per requester, requester i at slice i.
- req_data  in  DATA_WIDTH*NUM_REQ  write data.
- req_id  in  ID_BITS*NUM_REQ  MSHR id.
- req_stall  out  NUM_REQ  holding register full; the requester must hold its request.
- l2_valid  out  1  output stage valid.
- l2_rw  out  1  forwarded rw.
- l2_addr  out  ADDR_WIDTH  forwarded address.
- l2_data  out  DATA_WIDTH  forwarded data.
- l2_id  out  ID_BITS+NUM_REQ_LOG  {requester index, MSHR id}.
- l2_stall  in  1  L2 cannot accept this cycle.
- rsp_valid  in  1  L2 read response valid.
- rsp_data  in  DATA_WIDTH  response line.
- rsp_id  in  ID_BITS+NUM_REQ_LOG  tag returned by L2.
- out_valid  out  NUM_REQ  response valid per requester.
- out_data  out  DATA_WIDTH*NUM_REQ  response data per requester.
- out_id  out  ID_BITS*NUM_REQ  MSHR id per requester.

Behaviour:
- Reset values, forced asynchronously while reset=1:
  - All hold_valid=0, so req_stall=0.
  - l2_valid=0; l2_rw, l2_addr, l2_data, l2_id=0.
  - out_valid=0; out_data, out_id=0.
  - Outstanding counters=0.
  - RR pointer last_grant=NUM_REQ-1, so requester 0 has highest priority first.
- Reset mid-operation discards all held, in-flight and response state. No partial transfer survives.
- Accept:
  - Requester i is accepted when req_valid[i] & ~hold_valid[i].
  - On acceptance, the fields are captured in hold[i] at the clock edge.
  - req_stall[i] = hold_valid[i], driven directly from the register with no combinational path from inputs.
- Eligibility: hold[i] is eligible when hold_valid[i], and it is a write or cnt[i] < MAX_OUT.
  - A blocked read is skipped without blocking other requesters.
- Output stage advance:
  - The stage can load when ~l2_valid | ~l2_stall.
  - If it can load and any requester is eligible, grant the first eligible index scanning last_grant+1, +2, … modulo NUM_REQ.
  - On grant: copy hold[g] to the output stage, l2_id={g, id}, clear hold_valid[g], set last_grant=g.
  - If it can load and nothing is eligible: l2_valid=0.
  - A hold slot cleared by a grant accepts a new request no earlier than the following edge (the stall is still visible that cycle).
- Latency: request accepted at edge E appears on l2_valid after edge E+1 at the earliest, i.e. 2 cycles minimum.
- Backpressure: while l2_valid & l2_stall, the output stage holds all fields stable.
- Outstanding counters:
  - Granted read from g: cnt[g]+1.
  - rsp_valid with tag r=rsp_id[top NUM_REQ_LOG bits] < NUM_REQ: cnt[r]-1.
  - Both events on the same requester in the same cycle: unchanged.
  - Writes are not counted and produce no response.
  - Counter width is clog2(MAX_OUT+1).
  - Decrement at 0 and increment at MAX_OUT never occur legally; the counter saturates if they do.
- Response routing:
  - Registered. One cycle after rsp_valid: out_valid[r]=1, out_data[r]=rsp_data, out_id[r]=rsp_id[ID_BITS-1:0].
  - All other out_valid bits are 0.
  - out_valid is a single-cycle pulse with no backpressure.
  - A response with r >= NUM_REQ is dropped.

Test Plan:
- Reset then single read from req 1 (addr 0x40, id 5) → l2_valid 2 cycles later with l2_id=0b1_101 and req_stall[1] high for 1 cycle. rsp_valid with rsp_id=0b1_101 → out_valid[1] pulse next cycle with out_id=5; cnt[1] returns to 0.
- Both requesters issue back-to-back reads continuously, l2_stall=0 → grants alternate 0,1,0,1…, one per cycle after fill, with no starvation.
- l2_stall held high 5 cycles while both holds are full → l2_* stable, req_stall=2'b11; on release, the held winner is issued, then the other requester.
- Req 0 issues 4 reads with no responses → 5th read is not granted and req_stall[0] stays 1. Req 1 writes continue to be granted. One response to req 0 → its read is granted next cycle.
- Same-cycle read grant and response for req 0 → cnt[0] unchanged.
- Assert reset mid-transfer with l2_valid=1 and both holds full → all outputs 0 immediately. After release, requester 0 wins the first simultaneous request.
